// File: rtl/microseq_ctrl_pkg.sv
// Shared types and constants for the microsequencer controller.
// Holds the FSM state encoding, the microword condition codes and the address-source selects.
package microseq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_HALTED,
        ST_FAULT
    } state_t;

    localparam logic [2:0] COND_NEXT   = 3'b000;
    localparam logic [2:0] COND_JUMP   = 3'b001;
    localparam logic [2:0] COND_N      = 3'b010;
    localparam logic [2:0] COND_Z      = 3'b011;
    localparam logic [2:0] COND_V      = 3'b100;
    localparam logic [2:0] COND_C      = 3'b101;
    localparam logic [2:0] COND_DECODE = 3'b110;
    localparam logic [2:0] COND_IR13   = 3'b111;

    localparam logic [1:0] TIPO_NEXT   = 2'b00;
    localparam logic [1:0] TIPO_JUMP   = 2'b01;
    localparam logic [1:0] TIPO_DECODE = 2'b10;

    function automatic logic [1:0] jump_if(input logic taken);
        return taken ? TIPO_JUMP : TIPO_NEXT;
    endfunction

endpackage

// File: rtl/microseq_branch.sv
// Combinational condition decode: maps the microword condition field and flags
// onto the control-store address-source select.
module microseq_branch
    import microseq_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    input  logic       ir13,
    output logic [1:0] tipo
);

    // flags are ordered {N,Z,V,C}
    always_comb begin
        tipo = TIPO_NEXT;
        case (cond)
            COND_NEXT:   tipo = TIPO_NEXT;
            COND_JUMP:   tipo = TIPO_JUMP;
            COND_N:      tipo = jump_if(flags[3]);
            COND_Z:      tipo = jump_if(flags[2]);
            COND_V:      tipo = jump_if(flags[1]);
            COND_C:      tipo = jump_if(flags[0]);
            COND_DECODE: tipo = TIPO_DECODE;
            COND_IR13:   tipo = jump_if(ir13);
            default:     tipo = TIPO_NEXT;
        endcase
    end

endmodule

// File: rtl/microseq_ctrl.sv
// Microsequencer controller: run/wait/halt/fault FSM, memory-wait timeout,
// and saturating retired-microinstruction counter.
module microseq_ctrl
    import microseq_ctrl_pkg::*;
#(
    parameter int DATAWIDTH_CBL  = 2,
    parameter int DATAWIDTH_COND = 3,
    parameter int DATAWIDTH_CNT  = 16,
    parameter int MAXWAIT        = 15
) (
    input  logic                      MICROSEQ_CTRL_CLOCK_50,
    input  logic                      MICROSEQ_CTRL_ResetInLow_In,
    input  logic                      MICROSEQ_CTRL_Start_In,
    input  logic [DATAWIDTH_COND-1:0] MICROSEQ_CTRL_Cond_InBus,
    input  logic [3:0]                MICROSEQ_CTRL_Flags_InBus,
    input  logic                      MICROSEQ_CTRL_IR13_In,
    input  logic                      MICROSEQ_CTRL_Halt_In,
    input  logic                      MICROSEQ_CTRL_MemWait_In,
    output logic [DATAWIDTH_CBL-1:0]  MICROSEQ_CTRL_Tipo_OutBus,
    output logic                      MICROSEQ_CTRL_CSAEnable_Out,
    output logic                      MICROSEQ_CTRL_Busy_Out,
    output logic                      MICROSEQ_CTRL_Fault_Out,
    output logic [DATAWIDTH_CNT-1:0]  MICROSEQ_CTRL_Count_OutBus
);

    localparam int WAIT_W = $clog2(MAXWAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAXWAIT - 1);

    state_t                   state;
    logic [WAIT_W-1:0]        wait_cnt;
    logic [DATAWIDTH_CNT-1:0] count;
    logic                     busy;
    logic                     fault;
    logic                     csa_en;
    logic [1:0]               branch_tipo;

    microseq_branch u_branch (
        .cond  (MICROSEQ_CTRL_Cond_InBus),
        .flags (MICROSEQ_CTRL_Flags_InBus),
        .ir13  (MICROSEQ_CTRL_IR13_In),
        .tipo  (branch_tipo)
    );

    // Retire decision is same-cycle so the address register loads on this edge.
    assign csa_en = (state == ST_RUN) && !MICROSEQ_CTRL_MemWait_In && !MICROSEQ_CTRL_Halt_In;

    assign MICROSEQ_CTRL_Tipo_OutBus   = csa_en ? branch_tipo : TIPO_NEXT;
    assign MICROSEQ_CTRL_CSAEnable_Out = csa_en;
    assign MICROSEQ_CTRL_Busy_Out      = busy;
    assign MICROSEQ_CTRL_Fault_Out     = fault;
    assign MICROSEQ_CTRL_Count_OutBus  = count;

    always_ff @(posedge MICROSEQ_CTRL_CLOCK_50 or negedge MICROSEQ_CTRL_ResetInLow_In) begin
        if (!MICROSEQ_CTRL_ResetInLow_In) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            count    <= '0;
            busy     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            if (csa_en && count != '1)
                count <= count + 1'b1;
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (MICROSEQ_CTRL_Start_In) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (MICROSEQ_CTRL_Halt_In) begin
                        state <= ST_HALTED;
                        busy  <= 1'b0;
                    end else if (MICROSEQ_CTRL_MemWait_In) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!MICROSEQ_CTRL_MemWait_In) begin
                        state <= ST_RUN;
                    end else begin
                        // Counter lands on MAXWAIT on the same edge that enters FAULT.
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            state <= ST_FAULT;
                            busy  <= 1'b0;
                            fault <= 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microseq_ctrl.sv
// Scoreboard bench for microseq_ctrl: a cycle model pushes expected outputs as
// each vector is driven; a negedge monitor pops and compares them.
module tb_microseq_ctrl;

    localparam int MAXWAIT = 15;
    localparam int S_IDLE = 0, S_RUN = 1, S_WAIT = 2, S_HALT = 3, S_FAULT = 4;

    typedef struct {
        string       tag;
        logic [1:0]  tipo;
        logic        csa;
        logic        busy;
        logic        fault;
        logic [15:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  cond;
    logic [3:0]  flags;
    logic        ir13;
    logic        halt;
    logic        mem_wait;
    logic [1:0]  tipo;
    logic        csa_en;
    logic        busy;
    logic        fault;
    logic [15:0] count;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_state = S_IDLE;
    int   m_wcnt = 0;
    int   m_count = 0;

    microseq_ctrl #(
        .DATAWIDTH_CBL  (2),
        .DATAWIDTH_COND (3),
        .DATAWIDTH_CNT  (16),
        .MAXWAIT        (MAXWAIT)
    ) dut (
        .MICROSEQ_CTRL_CLOCK_50      (clk),
        .MICROSEQ_CTRL_ResetInLow_In (rst_n),
        .MICROSEQ_CTRL_Start_In      (start),
        .MICROSEQ_CTRL_Cond_InBus    (cond),
        .MICROSEQ_CTRL_Flags_InBus   (flags),
        .MICROSEQ_CTRL_IR13_In       (ir13),
        .MICROSEQ_CTRL_Halt_In       (halt),
        .MICROSEQ_CTRL_MemWait_In    (mem_wait),
        .MICROSEQ_CTRL_Tipo_OutBus   (tipo),
        .MICROSEQ_CTRL_CSAEnable_Out (csa_en),
        .MICROSEQ_CTRL_Busy_Out      (busy),
        .MICROSEQ_CTRL_Fault_Out     (fault),
        .MICROSEQ_CTRL_Count_OutBus  (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [1:0] ref_decode(input logic [2:0] c, input logic [3:0] f, input logic ir);
        case (c)
            3'd0: return 2'b00;
            3'd1: return 2'b01;
            3'd2: return f[3] ? 2'b01 : 2'b00;
            3'd3: return f[2] ? 2'b01 : 2'b00;
            3'd4: return f[1] ? 2'b01 : 2'b00;
            3'd5: return f[0] ? 2'b01 : 2'b00;
            3'd6: return 2'b10;
            default: return ir ? 2'b01 : 2'b00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".tipo"},  32'(tipo),   32'(e.tipo));
            check({e.tag, ".csa"},   32'(csa_en), 32'(e.csa));
            check({e.tag, ".busy"},  32'(busy),   32'(e.busy));
            check({e.tag, ".fault"}, 32'(fault),  32'(e.fault));
            check({e.tag, ".count"}, 32'(count),  32'(e.count));
        end
    end

    task automatic apply(input string tag, input logic st, input logic [2:0] c, input logic [3:0] f,
                         input logic ir, input logic h, input logic mw, input bit chk);
        exp_t e;
        bit   retire;
        @(posedge clk);
        #1;
        start = st; cond = c; flags = f; ir13 = ir; halt = h; mem_wait = mw;
        retire  = (m_state == S_RUN) && !h && !mw;
        e.tag   = tag;
        e.tipo  = retire ? ref_decode(c, f, ir) : 2'b00;
        e.csa   = retire;
        e.busy  = (m_state == S_RUN) || (m_state == S_WAIT);
        e.fault = (m_state == S_FAULT);
        e.count = 16'(m_count);
        if (chk)
            sb.push_back(e);
        if (retire && m_count < 65535)
            m_count++;
        case (m_state)
            S_IDLE, S_HALT: if (st) m_state = S_RUN;
            S_RUN: begin
                if (h) m_state = S_HALT;
                else if (mw) begin m_state = S_WAIT; m_wcnt = 0; end
            end
            S_WAIT: begin
                if (!mw) m_state = S_RUN;
                else begin
                    m_wcnt++;
                    if (m_wcnt == MAXWAIT) m_state = S_FAULT;
                end
            end
            default: ;
        endcase
    endtask

    task automatic run(input string tag, input logic [2:0] c);
        apply(tag, 1'b0, c, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".tipo"},  32'(tipo),   0);
        check({tag, ".csa"},   32'(csa_en), 0);
        check({tag, ".busy"},  32'(busy),   0);
        check({tag, ".fault"}, 32'(fault),  0);
        check({tag, ".count"}, 32'(count),  0);
        m_state = S_IDLE; m_wcnt = 0; m_count = 0;
        start = 1'b0; halt = 1'b0; mem_wait = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cond = 3'd0; flags = 4'd0; ir13 = 1'b0; halt = 1'b0; mem_wait = 1'b0;
        #3;
        check("por.csa",   32'(csa_en), 0);
        check("por.busy",  32'(busy),   0);
        check("por.count", 32'(count),  0);
        #9;
        rst_n = 1'b1;

        run("idle", 3'd1);
        apply("start", 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) run("next", 3'd0);
        apply("brz_t", 1'b0, 3'd3, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
        apply("brz_f", 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        run("decode", 3'd6);
        apply("ir13", 1'b0, 3'd7, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++)
            apply("cond_rand", 1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++)
            apply("memwait", 1'($urandom_range(0, 1)), 3'd1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1);
        apply("wait_exit", 1'b0, 3'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        run("resume", 3'd1);

        apply("halt_mw", 1'b0, 3'd1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        run("halted", 3'd1);
        apply("restart", 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        run("after_halt", 3'd1);

        for (int i = 0; i < 20; i++)
            apply("timeout", 1'(i % 3 == 0), 3'd1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        apply("fault_hold", 1'b1, 3'd1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        run("fault_hold2", 3'd1);
        async_reset("fault_rst");
        run("post_fault", 3'd0);

        apply("sat_start", 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        while (m_count < 65534)
            apply("preload", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run("saturate", 3'd0);
        for (int i = 0; i < 4; i++)
            apply("sat_wait", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        async_reset("wait_rst");
        run("post_rst", 3'd1);
        run("post_rst2", 3'd1);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
